i2c_slave_regs: RTL
===================

# i2c_slave_regs

I2C slave register file sitting downstream of `MASTER_I2C` on the shared SCL/SDA lines. It oversamples SCL/SDA with the system clock and detects START/STOP. It matches a 7-bit device address and acknowledges bytes by pulling SDA low. Write transactions (device address, register address, data…) land in an internal byte register file with auto-increment; each committed byte is also strobed out to local logic.

## Interface
- `SLV_ADR`, 7'h38, 7-bit device address (master byte 8'h70 = 7'h38 + W)
- `REG_AW`, 4, register file address width; depth 2**REG_AW bytes
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `scl_i`  in  1  bus SCL (asynchronous to `clk`)
- `sda_i`  in  1  bus SDA, resolved wired-AND value
- `sda_oe`  out  1  1 = pull SDA low, 0 = release (open-drain)
- `wr_stb`  out  1  one-cycle pulse per committed data byte
- `wr_adr`  out  REG_AW  register index of committed byte
- `wr_dat`  out  8  committed byte
- `busy`  out  1  high from address match to STOP/START
- `err_ovr`  out  1  sticky: pointer wrapped during a write; cleared by next START

## Operation
- Reset: all outputs 0, pointer 0, register file contents 0, state IDLE. Reset mid-transfer releases SDA immediately (async).
- Bus events, from synchronized signals: SCL rise and SCL fall; START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- Data is sampled on the SCL rise, MSB first. The slave changes `sda_oe` only on the cycle after a detected SCL fall.
- States: IDLE → ADDR (on START) → ADDR_ACK → REG → REG_ACK → WDATA ↔ WDATA_ACK; also RDATA ↔ RDATA_ACK; WAIT.
- ADDR: shift 8 bits.
  - Match with R/W=0: drive ACK → REG.
  - Mismatch: no ACK → WAIT.
  - R/W=1 handled per Configuration.
- REG: the received byte, truncated to REG_AW LSBs, loads the pointer. ACK → WDATA.
- WDATA: the 8th bit is sampled at cycle N. At N+1, write mem[ptr] and pulse `wr_stb` with `wr_adr`=ptr and `wr_dat`=byte. At N+2, ptr increments; it wraps from 2**REG_AW-1 to 0 and sets `err_ovr`. ACK is driven for the following SCL low phase.
- ACK phase: `sda_oe`=1 from the SCL fall after bit 8 until the next SCL fall, then released.
- START in any state (repeated start included): abort the partial byte without writing, release SDA, go to ADDR. STOP in any state: release SDA, go to IDLE. START or STOP takes priority over an SCL edge in the same cycle.
- WAIT: ignore the bus until START or STOP.

## Timing
- Synchronizer (2 FF) plus edge register: bus events are seen 3 `clk` cycles after the pin changes.
- SCL high and low phases must each be ≥ 6 `clk` cycles. Shorter phases are out of spec.
- `sda_oe` update happens 4 `clk` cycles after the pin-level SCL fall, which satisfies hold.
- `wr_stb` occurs 1 cycle after the 8th data-bit sample; back-to-back bytes give one strobe per byte.
- `busy` rises on the cycle the address matches and falls on the STOP/START detection cycle.

## Configuration
- `I2C_SLAVE_READ_EN` defined:
  - R/W=1 address match is ACKed and goes to RDATA.
  - mem[ptr] is shifted out on SCL falls (`sda_oe` = ~bit), and ptr increments after each byte.
  - The master's ACK bit is sampled on the SCL rise in RDATA_ACK: 0 → next byte; 1 (NACK) → WAIT.
- Not defined: R/W=1 is NACKed → WAIT; RDATA and RDATA_ACK are not built.

## Structure
- Package `i2c_pkg`: state enum, `I2C_SYNC_STAGES`=2, bit-count width constant, ACK/NACK level constants.
- Sub-module `i2c_bus_sync`: 2-FF synchronizers for SCL and SDA, plus single-cycle `scl_rise`, `scl_fall`, `start_det`, `stop_det` pulses.
- Top level contains the FSM, shift register, bit counter (0–8), pointer and register file.

## Test plan
- Master writes 8'h70, reg 8'h03, data 8'hA5, STOP:
  - three ACKs are seen;
  - `wr_stb` fires once with `wr_adr`=3 and `wr_dat`=8'hA5;
  - mem[3]=8'hA5;
  - `busy` falls on STOP.
- Address 8'h72 (mismatch): SDA is never pulled low, no `wr_stb`, `busy` stays 0.
- Burst at reg 8'h0E with data 11,22,33 (REG_AW=4): writes land at 14, 15, 0; `err_ovr`=1.
- Repeated START after 4 bits of the data byte: no write occurs, a new address phase is ACKed, and the next byte writes normally.
- With `I2C_SLAVE_READ_EN`: write reg 8'h03, then repeated START with 8'h71, master ACK then NACK → SDA carries mem[3] then mem[4], and the slave goes to WAIT. Without the macro, 8'h71 is NACKed.
- `rst_n` low during an ACK phase: `sda_oe` drops in the same cycle, and after release the FSM ignores the bus until START.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave register file.
// Contents: FSM state enum, synchronizer depth, bit-counter width and
// the SDA levels used for ACK/NACK on the bus.
package i2c_pkg;

  localparam int I2C_SYNC_STAGES = 2;
  localparam int BIT_CNT_W       = 4;   // counts 0..8 received/sent bits

  localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = 4'd8;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT      = 4'd7;

  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus front end: 2-FF synchronizers on SCL/SDA plus one edge register,
// producing single-cycle bus-event pulses in the clk domain.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   scl_i, sda_i        raw bus pins
//   sda                 synchronized SDA level
//   scl_rise, scl_fall  SCL edge pulses
//   start_det, stop_det SDA fall / rise while SCL is high
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [I2C_SYNC_STAGES-1:0] scl_sr, sda_sr;
  logic scl, scl_d, sda_d;

  // Reset to the idle-bus level so release of reset never fakes an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[I2C_SYNC_STAGES-2:0], scl_i};
      sda_sr <= {sda_sr[I2C_SYNC_STAGES-2:0], sda_i};
      scl_d  <= scl_sr[I2C_SYNC_STAGES-1];
      sda_d  <= sda_sr[I2C_SYNC_STAGES-1];
    end
  end

  assign scl       = scl_sr[I2C_SYNC_STAGES-1];
  assign sda       = sda_sr[I2C_SYNC_STAGES-1];
  assign scl_rise  =  scl & ~scl_d;
  assign scl_fall  = ~scl &  scl_d;
  assign start_det =  scl & scl_d & ~sda &  sda_d;
  assign stop_det  =  scl & scl_d &  sda & ~sda_d;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave byte register file with auto-incrementing pointer.
// Optional read support is built when I2C_SLAVE_READ_EN is defined;
// otherwise R/W=1 addressing is NACKed.
// Ports:
//   clk, rst_n    system clock, async active-low reset
//   scl_i, sda_i  bus pins (SDA is the resolved wired-AND level)
//   sda_oe        1 = pull SDA low
//   wr_stb        one-cycle pulse per committed byte, with wr_adr / wr_dat
//   busy          addressed and transfer in progress
//   err_ovr       sticky pointer wrap during a write, cleared on START
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADR = 7'h38,
  parameter int         REG_AW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              wr_stb,
  output logic [REG_AW-1:0] wr_adr,
  output logic [7:0]        wr_dat,
  output logic              busy,
  output logic              err_ovr
);

  localparam int DEPTH = 2**REG_AW;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det, bus_ev;
  i2c_state_e state, state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0] shreg;
  logic [REG_AW-1:0] ptr;
  logic [7:0] mem [DEPTH];
  logic fall_d, oe_nxt, byte_done, adr_hit, wr_smp;
  logic [1:0] vld_pipe;  // [0]: commit byte, [1]: advance pointer
`ifdef I2C_SLAVE_READ_EN
  logic [7:0] tx;
  logic m_ack;
`endif

  i2c_bus_sync u_sync (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i),
    .sda(sda_s), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det)
  );

  assign bus_ev    = start_det | stop_det;
  assign byte_done = (bit_cnt == BITS_PER_BYTE);
  assign adr_hit   = (shreg[7:1] == SLV_ADR);
  assign wr_smp    = scl_rise & ~bus_ev & (state == ST_WDATA) & (bit_cnt == LAST_BIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: bus conditions beat SCL edges; phases advance on SCL fall
  always_comb begin
    state_nxt = state;
    if (start_det)     state_nxt = ST_ADDR;
    else if (stop_det) state_nxt = ST_IDLE;
    else if (scl_fall) begin
      case (state)
        ST_ADDR:
          if (byte_done) begin
`ifdef I2C_SLAVE_READ_EN
            state_nxt = adr_hit ? ST_ADDR_ACK : ST_WAIT;
`else
            state_nxt = (adr_hit && !shreg[0]) ? ST_ADDR_ACK : ST_WAIT;
`endif
          end
`ifdef I2C_SLAVE_READ_EN
        ST_ADDR_ACK:  state_nxt = shreg[0] ? ST_RDATA : ST_REG;
        ST_RDATA:     if (byte_done) state_nxt = ST_RDATA_ACK;
        ST_RDATA_ACK: state_nxt = m_ack ? ST_RDATA : ST_WAIT;
`else
        ST_ADDR_ACK:  state_nxt = ST_REG;
`endif
        ST_REG:       if (byte_done) state_nxt = ST_REG_ACK;
        ST_REG_ACK:   state_nxt = ST_WDATA;
        ST_WDATA:     if (byte_done) state_nxt = ST_WDATA_ACK;
        ST_WDATA_ACK: state_nxt = ST_WDATA;
        default:      state_nxt = state;
      endcase
    end
  end

  // SDA drive level for the low phase that starts at the current fall
  always_comb begin
    oe_nxt = 1'b0;
    case (state)
      ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: oe_nxt = 1'b1;
`ifdef I2C_SLAVE_READ_EN
      ST_RDATA: oe_nxt = ~tx[7];
`endif
      default:  oe_nxt = 1'b0;
    endcase
  end

  // Datapath: shifter, bit counter, pointer, strobes, SDA driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      fall_d   <= 1'b0;
      vld_pipe <= '0;
      sda_oe   <= 1'b0;
      wr_stb   <= 1'b0;
      wr_adr   <= '0;
      wr_dat   <= '0;
      busy     <= 1'b0;
      err_ovr  <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      tx       <= '0;
      m_ack    <= 1'b0;
`endif
    end else begin
      fall_d   <= scl_fall & ~bus_ev;
      vld_pipe <= {vld_pipe[0], wr_smp};
      wr_stb   <= 1'b0;
      if (bus_ev) begin
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        if (start_det) err_ovr <= 1'b0;
      end else begin
        if (fall_d) sda_oe <= oe_nxt;
        if (scl_rise && !byte_done) begin
          if (state inside {ST_ADDR, ST_REG, ST_WDATA}) begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 1'b1;
          end
`ifdef I2C_SLAVE_READ_EN
          if (state == ST_RDATA) bit_cnt <= bit_cnt + 1'b1;
`endif
        end
        if (scl_fall && byte_done) bit_cnt <= '0;
        if (scl_fall && state == ST_ADDR && state_nxt == ST_ADDR_ACK) busy <= 1'b1;
        if (scl_fall && state == ST_REG && byte_done) ptr <= shreg[REG_AW-1:0];
`ifdef I2C_SLAVE_READ_EN
        if (scl_rise && state == ST_RDATA_ACK) m_ack <= (sda_s == SDA_ACK);
        if (scl_fall) begin
          if (state_nxt == ST_RDATA && state != ST_RDATA) tx <= mem[ptr];
          else if (state == ST_RDATA && !byte_done)       tx <= {tx[6:0], 1'b0};
          if (state == ST_RDATA && byte_done)             ptr <= ptr + 1'b1;
        end
`endif
      end
      // Completed bytes commit even if a bus event follows immediately
      if (vld_pipe[0]) begin
        wr_stb <= 1'b1;
        wr_adr <= ptr;
        wr_dat <= shreg;
      end
      if (vld_pipe[1]) begin
        ptr <= ptr + 1'b1;
        if (&ptr) err_ovr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (vld_pipe[0]) begin
      mem[ptr] <= shreg;
    end
  end

endmodule
